// File: rtl/opsum_fifo_if.sv
// Opsum FIFO controller bus: L2 task handshake, PE-array push gating,
// FIFO strobes, arbiter handshake and the GLB half-word write port.
interface opsum_fifo_if;
  logic        fifo_glb_busy_i;
  logic        opsum_fifo_reset_i;
  logic        opsum_need_push_i;
  logic [31:0] opsum_push_num_i;
  logic        opsum_fifo_mask_i;
  logic        pe_array_move_i;
  logic        opsum_permit_pop_i;
  logic        opsum_fifo_full_i;
  logic        opsum_fifo_empty_i;
  logic [31:0] opsum_fifo_base_addr_i;
  logic [31:0] opsum_fifo_pop_data_i;
  logic        opsum_fifo_push_o;
  logic        opsum_fifo_pop_o;
  logic        opsum_write_req_o;
  logic        opsum_glb_write_en_o;
  logic [31:0] opsum_glb_write_addr_o;
  logic [31:0] opsum_glb_write_data_o;
  logic [3:0]  opsum_glb_web_o;
  logic        opsum_is_PUSH_state_o;
  logic        opsum_fifo_done_o;

  // Controller side.
  modport master (
    input  fifo_glb_busy_i, opsum_fifo_reset_i, opsum_need_push_i, opsum_push_num_i,
           opsum_fifo_mask_i, pe_array_move_i, opsum_permit_pop_i, opsum_fifo_full_i,
           opsum_fifo_empty_i, opsum_fifo_base_addr_i, opsum_fifo_pop_data_i,
    output opsum_fifo_push_o, opsum_fifo_pop_o, opsum_write_req_o, opsum_glb_write_en_o,
           opsum_glb_write_addr_o, opsum_glb_write_data_o, opsum_glb_web_o,
           opsum_is_PUSH_state_o, opsum_fifo_done_o
  );

  // Environment side (L2 controller, PE array, FIFO, arbiter, GLB).
  modport slave (
    output fifo_glb_busy_i, opsum_fifo_reset_i, opsum_need_push_i, opsum_push_num_i,
           opsum_fifo_mask_i, pe_array_move_i, opsum_permit_pop_i, opsum_fifo_full_i,
           opsum_fifo_empty_i, opsum_fifo_base_addr_i, opsum_fifo_pop_data_i,
    input  opsum_fifo_push_o, opsum_fifo_pop_o, opsum_write_req_o, opsum_glb_write_en_o,
           opsum_glb_write_addr_o, opsum_glb_write_data_o, opsum_glb_web_o,
           opsum_is_PUSH_state_o, opsum_fifo_done_o
  );
endinterface

// File: rtl/opsum_fifo_ctrl.sv
// Opsum FIFO controller: gates PE-array pushes into the opsum FIFO, drains
// it to GLB as half-word writes via the arbiter, and signals task completion.
module opsum_fifo_ctrl #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  opsum_fifo_if.master bus
);

  typedef enum logic [1:0] {IDLE, CAN_PUSH, DRAIN, FLUSH} state_t;

  localparam logic [2:0] BURST = 3'(BURST_LEN);

  state_t      state;
  logic [31:0] push_num_buf;
  logic [31:0] push_cnt;
  logic [2:0]  wr_cnt;
  logic [15:0] write_ptr;
  // The pointer of the popped entry is registered rather than the full
  // address, so the write address reads as base + pointer out of reset.
  logic [15:0] wr_ptr_q;
  logic        wr_lane_q;
  logic        wr_en_q;

  logic        push;
  logic        pop;
  logic        req;
  logic        pop_lane;
  logic [31:0] wr_data;
  logic [3:0]  wr_web;

  // Push/pop strobes and the arbiter request, all same-cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    push = 1'b0;
    pop  = 1'b0;
    req  = 1'b0;
    if (state == CAN_PUSH)
      push = !bus.opsum_fifo_full_i && bus.pe_array_move_i && bus.opsum_fifo_mask_i;
    if (state == DRAIN || state == FLUSH)
      pop = bus.opsum_permit_pop_i && !bus.opsum_fifo_empty_i;
    if (state == DRAIN)
      req = !bus.opsum_fifo_empty_i && !bus.fifo_glb_busy_i && (wr_cnt < BURST);
    else if (state == FLUSH)
      req = !bus.opsum_fifo_empty_i && !bus.fifo_glb_busy_i;
  end

  // Bit 1 of base + write_ptr picks the half-word lane of the popped opsum.
  assign pop_lane = bus.opsum_fifo_base_addr_i[1] ^ write_ptr[1]
                  ^ (bus.opsum_fifo_base_addr_i[0] & write_ptr[0]);

  // Task sequencing: latch the push count, push, drain in bursts, flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values.
    if (rst) begin
      state        <= IDLE;
      push_num_buf <= '0;
      push_cnt     <= '0;
      wr_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          push_cnt <= '0;
          wr_cnt   <= '0;
          if (bus.opsum_need_push_i && bus.opsum_push_num_i != 32'd0) begin
            push_num_buf <= bus.opsum_push_num_i;
            state        <= CAN_PUSH;
          end
        end
        CAN_PUSH: begin
          wr_cnt <= '0;
          if (push) push_cnt <= push_cnt + 32'd1;
          if (push && push_cnt == push_num_buf - 32'd1) state <= FLUSH;
          else if (bus.opsum_fifo_full_i)                 state <= DRAIN;
        end
        DRAIN: begin
          if (pop) wr_cnt <= wr_cnt + 3'd1;
          if (bus.opsum_fifo_empty_i || wr_cnt == BURST) state <= CAN_PUSH;
        end
        FLUSH: begin
          wr_cnt <= '0;
          if (bus.opsum_fifo_empty_i && !pop && !wr_en_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // GLB write pointer and the one-cycle pop-to-write pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_ptr <= '0;
      wr_ptr_q  <= '0;
      wr_lane_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_en_q <= pop;
      if (pop) begin
        wr_ptr_q  <= write_ptr;
        wr_lane_q <= pop_lane;
      end
      // A pointer clear wins over a same-cycle pop; that pop still writes
      // at the address captured above.
      if (bus.opsum_fifo_reset_i) write_ptr <= '0;
      else if (pop)               write_ptr <= write_ptr + 16'd2;
    end
  end

  // Lane-aligned write data and byte enables, zero when no write is issued.
  always_comb begin
    wr_data = '0;
    wr_web  = '0;
    if (wr_en_q) begin
      if (wr_lane_q) begin
        wr_data = {bus.opsum_fifo_pop_data_i[15:0], 16'd0};
        wr_web  = 4'b1100;
      end else begin
        wr_data = {16'd0, bus.opsum_fifo_pop_data_i[15:0]};
        wr_web  = 4'b0011;
      end
    end
  end

  assign bus.opsum_fifo_push_o      = push;
  assign bus.opsum_fifo_pop_o       = pop;
  assign bus.opsum_write_req_o      = req;
  assign bus.opsum_glb_write_en_o   = wr_en_q;
  assign bus.opsum_glb_write_addr_o = bus.opsum_fifo_base_addr_i + {16'd0, wr_ptr_q};
  assign bus.opsum_glb_write_data_o = wr_data;
  assign bus.opsum_glb_web_o        = wr_web;
  assign bus.opsum_is_PUSH_state_o  = (state == CAN_PUSH);
  assign bus.opsum_fifo_done_o      = (state == IDLE);

endmodule

// File: tb/tb_opsum_fifo_ctrl.sv
// Self-checking bench for opsum_fifo_ctrl: a cycle-by-cycle vector table for
// a three-opsum task, then directed sequences for the multi-cycle corners.
module tb_opsum_fifo_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  opsum_fifo_if bus ();

  opsum_fifo_ctrl #(.BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        need;
    logic [31:0] num;
    logic        move;
    logic        full;
    logic        empty;
    logic        permit;
    logic        busy;
    logic [31:0] pdata;
    logic        push;
    logic        pop;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  web;
    logic        done;
    logic        ispush;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic need, input logic [31:0] num, input logic move,
                       input logic full, input logic empty, input logic permit,
                       input logic busy, input logic [31:0] pdata);
    bus.opsum_need_push_i     = need;
    bus.opsum_push_num_i      = num;
    bus.pe_array_move_i       = move;
    bus.opsum_fifo_full_i     = full;
    bus.opsum_fifo_empty_i    = empty;
    bus.opsum_permit_pop_i    = permit;
    bus.fifo_glb_busy_i       = busy;
    bus.opsum_fifo_pop_data_i = pdata;
  endtask

  // Let combinational outputs settle; optionally act as an arbiter that
  // grants exactly what is requested.
  task automatic settle(input bit follow);
    #1;
    if (follow) bus.opsum_permit_pop_i = bus.opsum_write_req_o;
    #1;
  endtask

  function automatic logic [95:0] pack(input logic push, input logic pop, input logic req,
                                       input logic we, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] web,
                                       input logic done, input logic ispush);
    return {22'd0, push, pop, req, we, addr, data, web, done, ispush};
  endfunction

  function automatic logic [95:0] outs();
    return pack(bus.opsum_fifo_push_o, bus.opsum_fifo_pop_o, bus.opsum_write_req_o,
                bus.opsum_glb_write_en_o, bus.opsum_glb_write_addr_o,
                bus.opsum_glb_write_data_o, bus.opsum_glb_web_o,
                bus.opsum_fifo_done_o, bus.opsum_is_PUSH_state_o);
  endfunction

  task automatic clear_ptr();
    drive(L, 32'd0, L, L, H, L, L, 32'd0);
    bus.opsum_fifo_reset_i = H;
    settle(1'b0);
    check("reset_i keeps idle", 96'(bus.opsum_fifo_done_o), 96'(1));
    next_cycle();
    bus.opsum_fifo_reset_i = L;
  endtask

  // Run a whole task against a FIFO occupancy model that reports full at
  // full_at entries, with an arbiter that grants every request.
  task automatic run_task(input logic [31:0] num, input int full_at, output int nwr,
                          output int dpops, output logic [31:0] a_first,
                          output logic [31:0] a_last);
    int cnt;
    int pushes;
    bit started;
    bit to;
    logic [31:0] a;
    cnt = 0; pushes = 0; started = 0; to = 1;
    nwr = 0; dpops = 0; a_first = '0; a_last = '0;
    for (int c = 0; c < 400; c++) begin
      drive(c == 0, num, H, cnt >= full_at, cnt == 0, L, L, 32'h5A5A_1234);
      settle(1'b1);
      if (bus.opsum_glb_write_en_o) begin
        a = bus.opsum_glb_write_addr_o;
        if (nwr == 0) a_first = a;
        a_last = a;
        nwr++;
        check("run wdata/web", 96'({bus.opsum_glb_write_data_o, bus.opsum_glb_web_o}),
              96'({a[1] ? 32'h1234_0000 : 32'h0000_1234, a[1] ? 4'hC : 4'h3}));
      end
      if (bus.opsum_fifo_push_o) begin cnt++; pushes++; end
      if (bus.opsum_fifo_pop_o) begin
        cnt--;
        if (pushes < int'(num)) dpops++;
      end
      if (started && bus.opsum_fifo_done_o) begin
        to = 0;
        break;
      end
      if (!bus.opsum_fifo_done_o) started = 1;
      next_cycle();
    end
    check("run finished in budget", 96'(to), 96'(0));
    next_cycle();
  endtask

  initial begin
    int nwr, dpops;
    logic [31:0] a_first, a_last;

    // base 0x1000, three opsums, FIFO never full, move every cycle
    vecs[0]  = '{H, 32'd3, L, L, H, L, L, 32'd0,        L, L, L, L, 32'h1000, 32'd0,        4'h0, H, L};
    vecs[1]  = '{L, 32'd3, H, L, H, L, L, 32'd0,        H, L, L, L, 32'h1000, 32'd0,        4'h0, L, H};
    vecs[2]  = '{L, 32'd3, H, L, L, L, L, 32'd0,        H, L, L, L, 32'h1000, 32'd0,        4'h0, L, H};
    vecs[3]  = '{L, 32'd3, H, L, L, L, L, 32'd0,        H, L, L, L, 32'h1000, 32'd0,        4'h0, L, H};
    vecs[4]  = '{L, 32'd3, H, L, L, H, L, 32'd0,        L, H, H, L, 32'h1000, 32'd0,        4'h0, L, L};
    vecs[5]  = '{L, 32'd3, L, L, L, H, L, 32'h0000_AAA1, L, H, H, H, 32'h1000, 32'h0000_AAA1, 4'h3, L, L};
    vecs[6]  = '{L, 32'd3, L, L, L, H, L, 32'h1234_BBB2, L, H, H, H, 32'h1002, 32'hBBB2_0000, 4'hC, L, L};
    vecs[7]  = '{L, 32'd3, L, L, H, H, L, 32'hFFFF_CCC3, L, L, L, H, 32'h1004, 32'h0000_CCC3, 4'h3, L, L};
    vecs[8]  = '{L, 32'd3, L, L, H, L, L, 32'd0,        L, L, L, L, 32'h1004, 32'd0,        4'h0, L, L};
    vecs[9]  = '{L, 32'd3, L, L, H, L, L, 32'd0,        L, L, L, L, 32'h1004, 32'd0,        4'h0, H, L};
    // zero-length task request is ignored
    vecs[10] = '{H, 32'd0, L, L, H, L, L, 32'd0,        L, L, L, L, 32'h1004, 32'd0,        4'h0, H, L};
    vecs[11] = '{L, 32'd0, H, L, H, L, L, 32'd0,        L, L, L, L, 32'h1004, 32'd0,        4'h0, H, L};

    bus.opsum_fifo_base_addr_i = BASE;
    bus.opsum_fifo_mask_i      = H;
    bus.opsum_fifo_reset_i     = L;
    drive(L, 32'd0, L, L, H, L, L, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle(1'b0);
    check("reset state", outs(), pack(L, L, L, L, BASE, 32'd0, 4'h0, H, L));
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].need, vecs[i].num, vecs[i].move, vecs[i].full, vecs[i].empty,
            vecs[i].permit, vecs[i].busy, vecs[i].pdata);
      settle(1'b0);
      check($sformatf("vec%0d", i), outs(),
            pack(vecs[i].push, vecs[i].pop, vecs[i].req, vecs[i].we, vecs[i].addr,
                 vecs[i].data, vecs[i].web, vecs[i].done, vecs[i].ispush));
      next_cycle();
    end

    // Ten opsums, FIFO full at six entries: one burst of four, then flush.
    clear_ptr();
    run_task(32'd10, 6, nwr, dpops, a_first, a_last);
    check("burst writes", 96'(nwr), 96'(10));
    check("drain pops", 96'(dpops), 96'(4));
    check("burst first addr", 96'(a_first), 96'(32'h1000));
    check("burst last addr", 96'(a_last), 96'(32'h1012));
    run_task(32'd1, 100, nwr, dpops, a_first, a_last);
    check("pointer 20 after burst task", 96'(a_first), 96'(32'h1014));

    // Busy held five cycles in FLUSH with two entries queued.
    clear_ptr();
    drive(H, 32'd2, L, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd2, H, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd2, H, L, L, L, L, 32'd0); settle(1'b0); next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(L, 32'd2, L, L, L, L, H, 32'd0);
      settle(1'b1);
      check($sformatf("busy%0d req/pop/we", i),
            96'({bus.opsum_write_req_o, bus.opsum_fifo_pop_o, bus.opsum_glb_write_en_o}), 96'(0));
      next_cycle();
    end
    drive(L, 32'd2, L, L, L, L, L, 32'd0); settle(1'b1);
    check("busy resume pop", 96'(bus.opsum_fifo_pop_o), 96'(1));
    next_cycle();
    drive(L, 32'd2, L, L, L, L, L, 32'h0000_0011); settle(1'b1);
    check("busy write 1", 96'({bus.opsum_glb_write_en_o, bus.opsum_glb_write_addr_o}),
          96'({H, 32'h1000}));
    next_cycle();
    drive(L, 32'd2, L, L, H, L, L, 32'h0000_0022); settle(1'b1);
    check("busy write 2", 96'({bus.opsum_glb_write_en_o, bus.opsum_glb_write_addr_o}),
          96'({H, 32'h1002}));
    next_cycle();
    drive(L, 32'd2, L, L, H, L, L, 32'd0); settle(1'b1);
    check("busy done not with write", 96'({bus.opsum_glb_write_en_o, bus.opsum_fifo_done_o}), 96'(0));
    next_cycle();
    drive(L, 32'd2, L, L, H, L, L, 32'd0); settle(1'b0);
    check("busy task done", 96'(bus.opsum_fifo_done_o), 96'(1));
    next_cycle();

    // Permit while empty in FLUSH is ignored.
    drive(H, 32'd1, L, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd1, H, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd1, L, L, L, H, L, 32'd0); settle(1'b0);
    check("empty: real pop", 96'(bus.opsum_fifo_pop_o), 96'(1));
    next_cycle();
    drive(L, 32'd1, L, L, H, H, L, 32'd0); settle(1'b0);
    check("empty: permit no pop", 96'({bus.opsum_fifo_pop_o, bus.opsum_glb_write_en_o}), 96'({L, H}));
    next_cycle();
    drive(L, 32'd1, L, L, H, H, L, 32'd0); settle(1'b0);
    check("empty: no write", 96'({bus.opsum_fifo_pop_o, bus.opsum_glb_write_en_o}), 96'(0));
    next_cycle();
    drive(L, 32'd1, L, L, H, L, L, 32'd0); settle(1'b0);
    check("empty: done", 96'(bus.opsum_fifo_done_o), 96'(1));
    next_cycle();
    run_task(32'd1, 100, nwr, dpops, a_first, a_last);
    check("empty: pointer unchanged", 96'(a_first), 96'(32'h1006));

    // rst in DRAIN one cycle after a pop.
    drive(H, 32'd10, L, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd10, H, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd10, H, L, L, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd10, H, H, L, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd10, L, L, L, L, L, 32'd0); settle(1'b1);
    check("drain pop", 96'({bus.opsum_write_req_o, bus.opsum_fifo_pop_o}), 96'({H, H}));
    next_cycle();
    rst = 1'b1;
    drive(L, 32'd10, L, L, L, L, L, 32'd0); settle(1'b1);
    check("rst cycle write", 96'({bus.opsum_glb_write_en_o, bus.opsum_glb_write_addr_o}),
          96'({H, 32'h1008}));
    next_cycle();
    rst = 1'b0;
    drive(L, 32'd10, L, L, L, L, L, 32'd0); settle(1'b1);
    check("after rst", outs(), pack(L, L, L, L, BASE, 32'd0, 4'h0, H, L));
    next_cycle();
    run_task(32'd1, 100, nwr, dpops, a_first, a_last);
    check("restart at base", 96'(a_first), 96'(32'h1000));

    // Pointer clear together with a pop.
    drive(H, 32'd2, L, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd2, H, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd2, H, L, L, L, L, 32'd0); settle(1'b0); next_cycle();
    drive(L, 32'd2, L, L, L, L, L, 32'd0); settle(1'b1);
    check("clr: first pop", 96'(bus.opsum_fifo_pop_o), 96'(1));
    next_cycle();
    bus.opsum_fifo_reset_i = H;
    drive(L, 32'd2, L, L, L, L, L, 32'd0); settle(1'b1);
    check("clr: pop with reset_i", 96'({bus.opsum_fifo_pop_o, bus.opsum_glb_write_en_o,
          bus.opsum_glb_write_addr_o}), 96'({H, H, 32'h1002}));
    next_cycle();
    bus.opsum_fifo_reset_i = L;
    drive(L, 32'd2, L, L, H, L, L, 32'd0); settle(1'b1);
    check("clr: pre-reset address", 96'({bus.opsum_glb_write_en_o, bus.opsum_glb_write_addr_o}),
          96'({H, 32'h1004}));
    next_cycle();
    drive(L, 32'd2, L, L, H, L, L, 32'd0); settle(1'b0); next_cycle();
    run_task(32'd1, 100, nwr, dpops, a_first, a_last);
    check("clr: pointer 0", 96'(a_first), 96'(32'h1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
